// File: rtl/cpu_port_uart_tx.sv
// Serializes every change of a CPU output port onto an async line (8N1, or 8E1
// when CPU_PORT_UART_PARITY_EN is defined), buffered through a small FIFO.
module cpu_port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CPU_PORT_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic [7:0]    last_seen;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          push, push_ok, pop, full, last_period;
  logic [7:0]    head;
`ifdef CPU_PORT_UART_PARITY_EN
  logic          par;
`endif

  assign level       = wr_ptr - rd_ptr;
  assign full        = (level == (AW+1)'(DEPTH));
  assign push        = (in_data != last_seen);
  // full is judged on the pre-edge level, so a same-cycle pop cannot save the push
  assign push_ok     = push && !full;
  assign pop         = (state == S_IDLE) && (level != '0);
  assign head        = mem[rd_ptr[AW-1:0]];
  assign last_period = (cnt == CW'(CLKS_PER_BIT-1));
  assign busy        = (state != S_IDLE) || (level != '0);

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      shift     <= '0;
      tx        <= 1'b1;
      last_seen <= 8'h00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
`ifdef CPU_PORT_UART_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      shift  <= shift_n;
      tx     <= tx_n;
      if (push) last_seen <= in_data;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push && full) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
`ifdef CPU_PORT_UART_PARITY_EN
      if (pop) par <= ^head;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // Next-state logic
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (pop) begin
          shift_n  = head;
          bitcnt_n = '0;
          state_n  = S_START;
        end
      end
      S_START: if (last_period) begin
        cnt_n   = '0;
        state_n = S_DATA;
      end
      S_DATA: if (last_period) begin
        cnt_n    = '0;
        shift_n  = {1'b0, shift[7:1]};
        bitcnt_n = bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
`ifdef CPU_PORT_UART_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef CPU_PORT_UART_PARITY_EN
      S_PARITY: if (last_period) begin
        cnt_n   = '0;
        state_n = S_STOP;
      end
`endif
      S_STOP: if (last_period) begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Output logic: line level for the upcoming state, registered above
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
`ifdef CPU_PORT_UART_PARITY_EN
      S_PARITY: tx_n = par;
`endif
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cpu_port_uart_tx.sv
// Bench for cpu_port_uart_tx: exact line waveforms plus a line decoder feeding a byte scoreboard.
module tb_cpu_port_uart_tx;

  localparam int C     = 16;
  localparam int DEPTH = 4;
`ifdef CPU_PORT_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * C;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [7:0]             in_data;
  logic                   tx, busy, overflow;
  logic [$clog2(DEPTH):0] level;

  int checks = 0;
  int errors = 0;
  int mon_bad = 0;
  logic [7:0] rxq[$];

  cpu_port_uart_tx #(.CLKS_PER_BIT(C), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data),
    .tx(tx), .busy(busy), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  // Expected line level at cycle i of a frame carrying d
  function automatic logic fb(input logic [7:0] d, input int i);
    int p;
    p = i / C;
    if (p == 0) return 1'b0;
    if (p <= 8) return d[p-1];
`ifdef CPU_PORT_UART_PARITY_EN
    if (p == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Line decoder: samples mid-bit and collects bytes
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        repeat (C/2) @(negedge clk);
        if (tx !== 1'b0) mon_bad++;
        for (int b = 0; b < 8; b++) begin
          repeat (C) @(negedge clk);
          d[b] = tx;
        end
`ifdef CPU_PORT_UART_PARITY_EN
        repeat (C) @(negedge clk);
        if (tx !== ^d) mon_bad++;
`endif
        repeat (C) @(negedge clk);
        if (tx !== 1'b1) mon_bad++;
        rxq.push_back(d);
      end
    end
  end

  task automatic do_reset(input logic [7:0] v);
    @(negedge clk);
    reset = 1'b0; in_data = v;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < limit);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle timeout busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; in_data = 8'h55;
    repeat (2) @(negedge clk);
    checks += 4;
    if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    if (level !== '0)      begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    rxq.delete();
    reset = 1'b1;
    wait_idle(FL + 20);
    checks += 2;
    if (rxq.size() != 1) begin errors++; $display("FAIL reset_frames got %0d exp 1", rxq.size()); end
    else if (rxq[0] !== 8'h55) begin errors++; $display("FAIL reset_byte got %h exp 55", rxq[0]); end
  endtask

  task automatic test_single;
    do_reset(8'h00);
    @(negedge clk); in_data = 8'h08;
    @(negedge clk);
    checks += 3;
    if (level !== 1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
    if (tx !== 1'b1) begin errors++; $display("FAIL single_pre_tx got %b exp 1", tx); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== fb(8'h08, i)) begin errors++; $display("FAIL single_tx cyc %0d got %b exp %b", i, tx, fb(8'h08, i)); end
    end
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    if (tx !== 1'b1)   begin errors++; $display("FAIL single_tx_end got %b exp 1", tx); end
  endtask

  task automatic test_back_to_back;
    int lmax = 0;
    logic e;
    do_reset(8'h00);
    rxq.delete();
    @(negedge clk); in_data = 8'h08;
    @(negedge clk); in_data = 8'h04;
    lmax = int'(level);
    for (int i = 0; i < 2*FL + 1; i++) begin
      @(negedge clk);
      if (int'(level) > lmax) lmax = int'(level);
      e = (i < FL) ? fb(8'h08, i) : (i == FL) ? 1'b1 : fb(8'h04, i - FL - 1);
      checks++;
      if (tx !== e) begin errors++; $display("FAIL b2b_tx cyc %0d got %b exp %b", i, tx, e); end
    end
    @(negedge clk);
    checks += 3;
    if (lmax != 1)     begin errors++; $display("FAIL b2b_level_peak got %0d exp 1", lmax); end
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
    if (rxq.size() != 2 || rxq[0] !== 8'h08 || rxq[1] !== 8'h04) begin
      errors++; $display("FAIL b2b_bytes got %0d bytes exp 08,04", rxq.size());
    end
  endtask

  task automatic test_overflow;
    do_reset(8'h00);
    rxq.delete();
    for (int v = 1; v <= 6; v++) begin
      @(negedge clk);
      if (v == 6) begin
        checks += 2;
        if (level !== 4)          begin errors++; $display("FAIL ovf_full_level got %0d exp 4", level); end
        if (overflow !== 1'b0)    begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
      end
      in_data = 8'(v);
    end
    @(negedge clk);
    checks += 2;
    if (level !== 4)       begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    wait_idle(6*FL);
    checks += 2;
    if (rxq.size() != 5) begin errors++; $display("FAIL ovf_frames got %0d exp 5", rxq.size()); end
    else for (int k = 0; k < 5; k++)
      if (rxq[k] !== 8'(k+1)) begin errors++; $display("FAIL ovf_byte %0d got %h exp %h", k, rxq[k], 8'(k+1)); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_no_change;
    int lows = 0, busys = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    checks += 2;
    if (lows != 0)  begin errors++; $display("FAIL nochg_tx low cycles %0d exp 0", lows); end
    if (busys != 0) begin errors++; $display("FAIL nochg_busy cycles %0d exp 0", busys); end
  endtask

  task automatic test_reset_mid;
    int lows = 0;
    do_reset(8'h00);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf_clear got %b exp 0", overflow); end
    in_data = 8'h3C;
    @(negedge clk);
    repeat (4*C + 6) @(negedge clk);   // inside data bit 3
    reset = 1'b0; in_data = 8'h00;
    @(negedge clk);
    checks += 3;
    if (tx !== 1'b1)   begin errors++; $display("FAIL mid_tx got %b exp 1", tx); end
    if (level !== 0)   begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL mid_residual low cycles %0d exp 0", lows); end
    rxq.delete();
    mon_bad = 0;
  endtask

  task automatic test_parity;
    logic eb;
    logic et;
    do_reset(8'h00);
    @(negedge clk); in_data = 8'h07;
    @(negedge clk);
    for (int i = 0; i < 11*C; i++) begin
      @(negedge clk);
      et = (i < FL) ? fb(8'h07, i) : 1'b1;
      eb = (i < FL - 1) ? 1'b1 : (i == FL - 1) ? 1'b1 : 1'b0;
      checks += 2;
      if (tx !== et)   begin errors++; $display("FAIL par_tx cyc %0d got %b exp %b", i, tx, et); end
      if (busy !== eb) begin errors++; $display("FAIL par_busy cyc %0d got %b exp %b", i, busy, eb); end
    end
  endtask

  task automatic test_random;
    logic [7:0] expq[$];
    logic [7:0] v;
    int bl;
    do_reset(8'h00);
    rxq.delete();
    mon_bad = 0;
    for (int r = 0; r < 8; r++) begin
      bl = $urandom_range(1, DEPTH);
      for (int k = 0; k < bl; k++) begin
        @(negedge clk);
        v = 8'($urandom_range(0, 255));
        while (v == in_data) v = 8'($urandom_range(0, 255));
        in_data = v;
        expq.push_back(v);
      end
      @(negedge clk);
      wait_idle((DEPTH + 1) * FL + 20);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    checks += 3;
    if (rxq.size() != expq.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", rxq.size(), expq.size());
    end else begin
      for (int k = 0; k < expq.size(); k++)
        if (rxq[k] !== expq[k]) begin errors++; $display("FAIL rand_byte %0d got %h exp %h", k, rxq[k], expq[k]); end
    end
    if (mon_bad != 0)      begin errors++; $display("FAIL rand_framing bad bits %0d exp 0", mon_bad); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf got %b exp 0", overflow); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_no_change;
    test_reset_mid;
    test_parity;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout reached exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_port_uart_tx.md
# cpu_port_uart_tx

Output-port serializer downstream of the `cpu` core. It watches one 8-bit CPU output port (`out_p0` or `out_p1`) and treats every change of value as a write. Each new value is queued in a small FIFO and sent LSB-first on an asynchronous serial line, 8N1 by default. It gives the processor a real output device without any change to the CPU's port interface.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Legal range is ≥2.
- `DEPTH`, 4: FIFO entries. Must be a power of 2 and ≥2.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: reset, synchronous and active-low. The block is reset on a rising `clk` edge while `reset`=0.
- `in_data` input 8: CPU output port value, connected to `out_p0` or `out_p1`.
- `tx` output 1: serial line; idles high.
- `busy` output 1: high while a frame is in progress or the FIFO is non-empty.
- `overflow` output 1: sticky; set when a byte is dropped because the FIFO is full.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Change detector:
  - Register `last_seen` resets to 8'h00.
  - On each edge where `in_data != last_seen`, `last_seen` <= `in_data` and a push is requested.
  - A constant `in_data` generates nothing. A return to a previous value counts as a change.
- FIFO:
  - Circular buffer of `DEPTH` bytes with read/write pointers one bit wider than the index.
  - `level` = wr_ptr - rd_ptr; full when `level`==`DEPTH`.
  - A push while full is dropped and sets `overflow`. This holds even if a pop happens in the same cycle; full is evaluated from the pre-edge `level`.
  - `overflow` clears only on reset.
  - Simultaneous push and pop with `level`≥1 leaves `level` unchanged.
- TX FSM states: IDLE, START, DATA, [PARITY], STOP.
  - **IDLE:** `tx`=1. If the FIFO is non-empty: pop into the shift register, clear the bit counter, go to START.
  - **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - **DATA:** `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit. Shift right after each bit. After bit 7, go to PARITY if enabled, else STOP.
  - **PARITY:** `tx`=even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles, then go to STOP.
  - **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- A bit-period counter counts 0..CLKS_PER_BIT-1 and resets on every state change.
- `tx` is a registered output, so it has no glitches.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `level`=0, FSM=IDLE, `last_seen`=0, pointers=0. These apply on the first edge with `reset`=0.
- Reset mid-frame aborts the frame. `tx` returns high on that edge and the FIFO contents are discarded.
- Latency:
  - `in_data` change sampled at edge N: pushed at edge N, so `level` increments after N.
  - Popped at edge N+1, so `tx` falls after edge N+1.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- Back-to-back frames have exactly one IDLE cycle between the end of STOP and the start of the next START.
- `busy` falls on the edge where STOP completes, provided the FIFO is empty.

## Configuration
- `CPU_PORT_UART_PARITY_EN`:
  - Defined: the PARITY state is compiled in and frames are 8E1, 11 bit periods.
  - Undefined: the PARITY state and parity logic are absent and frames are 8N1, 10 bit periods.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `in_data`=8'h55 -> `tx`=1, `busy`=0, `overflow`=0, `level`=0. Releasing reset then sends 0x55, since 0x55 differs from the reset `last_seen` of 0x00.
- **Single byte:** `in_data` changes 8'h00->8'h08 (the bench's p0 value) -> `tx` low 16 cycles starting 2 edges after the change, then data bits 0,0,0,1,0,0,0,0 at 16 cycles each, then stop high 16 cycles; `busy` then drops.
- **Back-to-back:** 8'h08 then 8'h04 one cycle later -> two frames, 0x08 then 0x04, with exactly 1 idle cycle between them; `level` peaks at 1.
- **Overflow:** `DEPTH`=4, `in_data` = 01,02,03,04,05,06 on consecutive cycles -> 0x01 popped immediately; 02..05 fill the FIFO (`level`=4); 06 dropped; `overflow`=1; line carries 01..05 only.
- **No change / reset mid-frame:**
  - Constant `in_data` for 200 cycles -> no frame.
  - Assert reset at bit 3 of a frame -> `tx`=1 on the next edge, `level`=0, no residual frame.
- **Parity:** with the macro defined, send 0x07 -> parity bit 1, 11-period frame. Without the macro -> 10-period frame, with the stop bit directly after bit 7.
